// File: rtl/mmio_console.sv
// mmio_console
// ------------
// Memory-mapped console transmitter. The CPU stores 32-bit words to TXDATA.
// The words are queued in a small word FIFO and then serialised to a byte
// sink, least-significant byte first, over a valid/ready handshake.
//
// Register window (byte addresses relative to BASE_ADDR):
//   +0  TXDATA  write-only   push a word (stalls while the FIFO is full)
//   +4  STATUS  read-only    {16'b0, count[7:0], 5'b0, busy, full, empty}
//   +8  SENT    read-only    {16'b0, sent[15:0]}  words completed, wraps
// Writes to any other address are ignored. Reads of any other address
// return zero.
//
// Parameters:
//   BASE_ADDR  word-aligned base address of the 3-register window
//   DEPTH      word-FIFO depth, a power of two in 2..16
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   addr       byte address from the CPU memory stage
//   wdata      store data
//   we         store strobe, one word per cycle
//   re         load strobe
//   rdata      load data (combinational, zero when re=0)
//   stall      CPU must hold its store while high
//   out_byte   byte to the host sink
//   out_valid  out_byte is valid
//   out_ready  sink accepts the byte when high together with out_valid
//
// Build option:
//   CONSOLE_NUL_STOP_EN  when defined, a zero byte ends the current word
//                        early and is not presented to the sink. When it is
//                        undefined (the default), every word sends 4 bytes.

module mmio_console #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        stall,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [31:0] ADDR_TX     = BASE_ADDR;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_SENT   = BASE_ADDR + 32'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   shift;
  logic [1:0]    idx;
  logic [15:0]   sent;

  logic tx_hit;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic busy;
  logic nul_stop;
  logic handshake;
  logic word_done;

  // Pointer advance with explicit wrap at DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] status_word(input logic [CW-1:0] cnt,
                                              input logic b,
                                              input logic f,
                                              input logic e);
    return {16'b0, 8'(cnt), 5'b0, b, f, e};
  endfunction

  assign tx_hit = (addr == ADDR_TX);
  // Full and empty come from the registered count, so a pop in the same
  // cycle never frees a slot for a push in that cycle.
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign push   = we && tx_hit && !full;
  assign stall  = we && tx_hit && full;
  assign busy   = (state == ST_SEND);

`ifdef CONSOLE_NUL_STOP_EN
  assign nul_stop = busy && (shift[7:0] == 8'h00);
`else
  assign nul_stop = 1'b0;
`endif

  assign out_valid = busy && !nul_stop;
  assign out_byte  = shift[7:0];
  assign handshake = out_valid && out_ready;
  // A word finishes on the handshake of its fourth byte, or on a NUL byte
  // when early termination is built in.
  assign word_done = (handshake && (idx == 2'd3)) || nul_stop;

  // The head word is taken whenever a new word is needed: from IDLE, or
  // back-to-back at the end of the current word.
  assign pop = !empty && ((state == ST_IDLE) || word_done);

  // FIFO storage carries data only and is not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shift <= '0;
      idx   <= '0;
      sent  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            idx   <= '0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (word_done) begin
            sent <= sent + 16'd1;
            if (pop) begin
              shift <= mem[rd_ptr];
              idx   <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else if (handshake) begin
            shift <= shift >> 8;
            idx   <= idx + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (re) begin
      if (addr == ADDR_STATUS) begin
        rdata = status_word(count, busy, full, empty);
      end else if (addr == ADDR_SENT) begin
        rdata = {16'b0, sent};
      end
    end
  end

endmodule
